// File: rtl/obb_world_stepper.sv
// Register-array world of N_OBJ oriented boxes, stepped one box per clock with wall bounce and angle wrap.
// Optional gravity on vel_y when OBB_GRAVITY_EN is defined.
//
// state    | meaning
// S_IDLE   | accepting loads and step_start
// S_UPDATE | updating box r_idx, one per cycle
// S_DONE   | step_done pulse, back to idle
module obb_world_stepper #(
    parameter int N_OBJ         = 4,
    parameter int INT_BITS      = 8,
    parameter int FRAC_BITS     = 8,
    parameter int ANG_INT_BITS  = 3,
    parameter int ANG_FRAC_BITS = 8,
    parameter int ARENA_W       = 64,
    parameter int ARENA_H       = 64,
    parameter int GRAVITY       = 16,
    localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1,
    localparam int W  = 1 + INT_BITS + FRAC_BITS,
    localparam int AW = 1 + ANG_INT_BITS + ANG_FRAC_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_start,
    output logic                 busy,
    output logic                 step_done,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [IW-1:0]        load_idx,
    input  logic signed [W-1:0]  load_pos_x,
    input  logic signed [W-1:0]  load_pos_y,
    input  logic signed [W-1:0]  load_vel_x,
    input  logic signed [W-1:0]  load_vel_y,
    input  logic signed [AW-1:0] load_angle,
    input  logic signed [AW-1:0] load_omega,
    input  logic [IW-1:0]        rd_idx,
    output logic signed [W-1:0]  rd_pos_x,
    output logic signed [W-1:0]  rd_pos_y,
    output logic signed [W-1:0]  rd_vel_x,
    output logic signed [W-1:0]  rd_vel_y,
    output logic signed [AW-1:0] rd_angle,
    output logic signed [AW-1:0] rd_omega
);
    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

    localparam logic [IW:0]         N_OBJ_W  = N_OBJ[IW:0];
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_OBJ - 1);
    localparam logic signed [W:0]   LIM_X    = (W+1)'(ARENA_W << FRAC_BITS);
    localparam logic signed [W:0]   LIM_Y    = (W+1)'(ARENA_H << FRAC_BITS);
    localparam logic signed [W-1:0] V_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] V_MIN    = {1'b1, {(W-1){1'b0}}};
    localparam int                  TWO_PI_I = int'(6.283185307179586 * (2.0 ** ANG_FRAC_BITS));
    localparam logic signed [AW:0]  TWO_PI   = (AW+1)'(TWO_PI_I);

    state_t              r_state, w_state_nxt;
    logic [IW-1:0]       r_idx;
    logic signed [W-1:0]  r_pos_x [N_OBJ];
    logic signed [W-1:0]  r_pos_y [N_OBJ];
    logic signed [W-1:0]  r_vel_x [N_OBJ];
    logic signed [W-1:0]  r_vel_y [N_OBJ];
    logic signed [AW-1:0] r_angle [N_OBJ];
    logic signed [AW-1:0] r_omega [N_OBJ];
    logic signed [W-1:0]  r_rd_pos_x, r_rd_pos_y, r_rd_vel_x, r_rd_vel_y;
    logic signed [AW-1:0] r_rd_angle, r_rd_omega;

    logic signed [W-1:0]  w_vy, w_px_nxt, w_vx_nxt, w_py_nxt, w_vy_nxt;
    logic signed [AW:0]   w_a;
    logic signed [AW-1:0] w_ang_nxt;
    logic                 w_load_we;

    function automatic logic signed [W-1:0] neg_sat(input logic signed [W-1:0] v);
        return (v == V_MIN) ? V_MAX : -v;
    endfunction

    // Sum is one bit wider than the operands, so the wall compare sees the true position.
    function automatic logic [2*W-1:0] axis_step(input logic signed [W-1:0] pos,
                                                 input logic signed [W-1:0] vel,
                                                 input logic signed [W:0]   lim);
        logic signed [W:0] p;
        p = {pos[W-1], pos} + {vel[W-1], vel};
        if (p[W])
            return {W'(0), neg_sat(vel)};
        else if (p > lim)
            return {lim[W-1:0], neg_sat(vel)};
        else
            return {p[W-1:0], vel};
    endfunction

`ifdef OBB_GRAVITY_EN
    localparam logic signed [W:0] SUM_MAX = (W+1)'(V_MAX);
    localparam logic signed [W:0] SUM_MIN = (W+1)'(V_MIN);
    logic signed [W:0] w_vy_sum;
    assign w_vy_sum = {r_vel_y[r_idx][W-1], r_vel_y[r_idx]} + (W+1)'(GRAVITY);
    assign w_vy = (w_vy_sum > SUM_MAX) ? V_MAX :
                  (w_vy_sum < SUM_MIN) ? V_MIN : w_vy_sum[W-1:0];
`else
    logic w_unused_gravity;
    assign w_unused_gravity = |GRAVITY;
    assign w_vy = r_vel_y[r_idx];
`endif

    assign {w_px_nxt, w_vx_nxt} = axis_step(r_pos_x[r_idx], r_vel_x[r_idx], LIM_X);
    assign {w_py_nxt, w_vy_nxt} = axis_step(r_pos_y[r_idx], w_vy, LIM_Y);

    assign w_a = {r_angle[r_idx][AW-1], r_angle[r_idx]} + {r_omega[r_idx][AW-1], r_omega[r_idx]};

    always_comb begin
        w_ang_nxt = w_a[AW-1:0];
        if (w_a >= TWO_PI)
            w_ang_nxt = AW'(w_a - TWO_PI);
        else if (w_a[AW])
            w_ang_nxt = AW'(w_a + TWO_PI);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (step_start) w_state_nxt = S_UPDATE;
            S_UPDATE: if (r_idx == IDX_LAST) w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != S_UPDATE)
                r_idx <= '0;
            else if (r_idx != IDX_LAST)
                r_idx <= r_idx + IW'(1);
        end
    end

    assign load_ready = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign step_done  = (r_state == S_DONE);
    assign w_load_we  = load_valid && load_ready && ({1'b0, load_idx} < N_OBJ_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                r_pos_x[i] <= '0;
                r_pos_y[i] <= '0;
                r_vel_x[i] <= '0;
                r_vel_y[i] <= '0;
                r_angle[i] <= '0;
                r_omega[i] <= '0;
            end
        end else if (r_state == S_UPDATE) begin
            r_pos_x[r_idx] <= w_px_nxt;
            r_vel_x[r_idx] <= w_vx_nxt;
            r_pos_y[r_idx] <= w_py_nxt;
            r_vel_y[r_idx] <= w_vy_nxt;
            r_angle[r_idx] <= w_ang_nxt;
        end else if (w_load_we) begin
            r_pos_x[load_idx] <= load_pos_x;
            r_pos_y[load_idx] <= load_pos_y;
            r_vel_x[load_idx] <= load_vel_x;
            r_vel_y[load_idx] <= load_vel_y;
            r_angle[load_idx] <= load_angle;
            r_omega[load_idx] <= load_omega;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pos_x <= '0;
            r_rd_pos_y <= '0;
            r_rd_vel_x <= '0;
            r_rd_vel_y <= '0;
            r_rd_angle <= '0;
            r_rd_omega <= '0;
        end else if ({1'b0, rd_idx} < N_OBJ_W) begin
            r_rd_pos_x <= r_pos_x[rd_idx];
            r_rd_pos_y <= r_pos_y[rd_idx];
            r_rd_vel_x <= r_vel_x[rd_idx];
            r_rd_vel_y <= r_vel_y[rd_idx];
            r_rd_angle <= r_angle[rd_idx];
            r_rd_omega <= r_omega[rd_idx];
        end else begin
            r_rd_pos_x <= '0;
            r_rd_pos_y <= '0;
            r_rd_vel_x <= '0;
            r_rd_vel_y <= '0;
            r_rd_angle <= '0;
            r_rd_omega <= '0;
        end
    end

    assign rd_pos_x = r_rd_pos_x;
    assign rd_pos_y = r_rd_pos_y;
    assign rd_vel_x = r_rd_vel_x;
    assign rd_vel_y = r_rd_vel_y;
    assign rd_angle = r_rd_angle;
    assign rd_omega = r_rd_omega;
endmodule

// File: tb/tb_obb_world_stepper.sv
// Bench for obb_world_stepper: table of box vectors, read-back scoreboard, protocol and reset sequences.
module tb_obb_world_stepper;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int W  = 17;
    localparam int AW = 12;

    typedef struct { int px; int py; int vx; int vy; int ang; int om; } box_t;
    typedef struct { box_t in; box_t exp; } vec_t;
    typedef struct { int idx; box_t b; } sb_t;

    logic clk = 0;
    logic rst_n = 0;
    logic step_start = 0, load_valid = 0;
    logic busy, step_done, load_ready;
    logic [IW-1:0] load_idx = '0, rd_idx = '0;
    logic signed [W-1:0]  load_pos_x = '0, load_pos_y = '0, load_vel_x = '0, load_vel_y = '0;
    logic signed [AW-1:0] load_angle = '0, load_omega = '0;
    logic signed [W-1:0]  rd_pos_x, rd_pos_y, rd_vel_x, rd_vel_y;
    logic signed [AW-1:0] rd_angle, rd_omega;

    obb_world_stepper dut (
        .clk(clk), .rst_n(rst_n), .step_start(step_start), .busy(busy), .step_done(step_done),
        .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx),
        .load_pos_x(load_pos_x), .load_pos_y(load_pos_y), .load_vel_x(load_vel_x),
        .load_vel_y(load_vel_y), .load_angle(load_angle), .load_omega(load_omega),
        .rd_idx(rd_idx), .rd_pos_x(rd_pos_x), .rd_pos_y(rd_pos_y), .rd_vel_x(rd_vel_x),
        .rd_vel_y(rd_vel_y), .rd_angle(rd_angle), .rd_omega(rd_omega)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    vec_t vecs[N];
    sb_t sb_q[$];
    box_t zero_b = '{0, 0, 0, 0, 0, 0};

    always @(posedge clk) if (step_done === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive_load(input int idx, input box_t b);
        load_idx   = IW'(idx);
        load_pos_x = W'(b.px);
        load_pos_y = W'(b.py);
        load_vel_x = W'(b.vx);
        load_vel_y = W'(b.vy);
        load_angle = AW'(b.ang);
        load_omega = AW'(b.om);
        load_valid = 1;
    endtask

    task automatic do_load(input int idx, input box_t b);
        drive_load(idx, b);
        chk("load_ready_idle", int'(load_ready), 1);
        tick();
        load_valid = 0;
    endtask

    task automatic rd_req(input int idx, input box_t e);
        sb_t s;
        rd_idx = IW'(idx);
        s.idx = idx;
        s.b = e;
        sb_q.push_back(s);
        tick();
        if (sb_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            s = sb_q.pop_front();
            chk($sformatf("box%0d_pos_x", s.idx), int'(rd_pos_x), s.b.px);
            chk($sformatf("box%0d_pos_y", s.idx), int'(rd_pos_y), s.b.py);
            chk($sformatf("box%0d_vel_x", s.idx), int'(rd_vel_x), s.b.vx);
            chk($sformatf("box%0d_vel_y", s.idx), int'(rd_vel_y), s.b.vy);
            chk($sformatf("box%0d_angle", s.idx), int'(rd_angle), s.b.ang);
            chk($sformatf("box%0d_omega", s.idx), int'(rd_omega), s.b.om);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        box_t e0, e1;
        vecs[0].in  = '{'h0A00, 'h1000, 'h0180, 0, 0, 0};
        vecs[1].in  = '{'h3F80, 'h0040, 'h0100, -128, 1600, 20};
        vecs[2].in  = '{'h0010, 'h4000, -32, 'h0100, 5, -10};
        vecs[3].in  = '{'h1000, 100, -65536, -100, 1607, 1};
`ifdef OBB_GRAVITY_EN
        vecs[0].exp = '{'h0B80, 'h1010, 'h0180, 16, 0, 0};
        vecs[1].exp = '{'h4000, 0, -256, 112, 12, 20};
        vecs[2].exp = '{0, 'h4000, 32, -272, 1603, -10};
        vecs[3].exp = '{0, 16, 65535, -84, 0, 1};
        e0 = '{'h0D00, 'h1030, 'h0180, 32, 0, 0};
`else
        vecs[0].exp = '{'h0B80, 'h1000, 'h0180, 0, 0, 0};
        vecs[1].exp = '{'h4000, 0, -256, 128, 12, 20};
        vecs[2].exp = '{0, 'h4000, 32, -256, 1603, -10};
        vecs[3].exp = '{0, 0, 65535, -100, 0, 1};
        e0 = '{'h0D00, 'h1000, 'h0180, 0, 0, 0};
`endif
        e1 = '{'h3F00, 128, -256, 128, 32, 20};

        // reset state
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(step_done), 0);
        chk("rst_load_ready", int'(load_ready), 1);
        chk("rst_rd_pos_x", int'(rd_pos_x), 0);
        chk("rst_rd_angle", int'(rd_angle), 0);
        #10 rst_n = 1;
        tick();
        for (int i = 0; i < N; i++) rd_req(i, zero_b);

        // load boxes 0..2, box 3 together with step_start
        for (int i = 0; i < N - 1; i++) do_load(i, vecs[i].in);
        drive_load(N - 1, vecs[N-1].in);
        step_start = 1;
        chk("load_ready_start", int'(load_ready), 1);
        d0 = done_cnt;
        tick();
        load_valid = 0;
        step_start = 0;
        for (int c = 1; c <= N + 1; c++) begin
            chk($sformatf("busy_c%0d", c), int'(busy), 1);
            chk($sformatf("done_c%0d", c), int'(step_done), int'(c == N + 1));
            chk($sformatf("load_ready_c%0d", c), int'(load_ready), 0);
            if (c == 2) begin
                drive_load(0, '{'h1234, 'h0555, 7, 9, 33, 44});
                step_start = 1;
            end
            if (c == 4) begin
                load_valid = 0;
                step_start = 0;
            end
            tick();
        end
        chk("busy_after", int'(busy), 0);
        chk("done_after", int'(step_done), 0);
        chk("load_ready_after", int'(load_ready), 1);
        for (int i = 0; i < 6; i++) tick();
        chk("single_done", done_cnt - d0, 1);
        chk("busy_settled", int'(busy), 0);
        for (int i = 0; i < N; i++) rd_req(i, vecs[i].exp);

        // second step: right-wall rebound
        step_start = 1;
        tick();
        step_start = 0;
        for (int i = 0; i < N + 2; i++) tick();
        rd_req(1, e1);
        rd_req(0, e0);

        // reset at idx=2 mid-step
        d0 = done_cnt;
        step_start = 1;
        tick();
        step_start = 0;
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(step_done), 0);
        chk("midrst_load_ready", int'(load_ready), 1);
        tick();
        tick();
        rst_n = 1;
        for (int i = 0; i < N + 3; i++) tick();
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_busy_idle", int'(busy), 0);
        for (int i = 0; i < N; i++) rd_req(i, zero_b);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
